seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 15 +
 rtl/seg_scan_driver_if.sv | 18 +
 rtl/hex2seg.sv | 28 ++
 rtl/seg_scan_driver.sv | 89 ++++++++
 tb/tb_seg_scan_driver.sv | 131 +++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Latency/backpressure: none here; types and defaults only.
package seg_pkg;
  localparam int SCAN_DIV_DEF  = 100000;
  localparam int BLANK_CYC_DEF = 1000;
  localparam int NUM_DIGITS    = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_blank;
  } shadow_t;
endpackage

// File: rtl/seg_scan_driver_if.sv
// Display request inputs and registered panel outputs of the scan driver.
// Latency/backpressure: pure wiring; no flow control (free-running scan).
interface seg_scan_driver_if;
  import seg_pkg::*;
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_tick;

  modport master (output data, dp_in, digit_en, lz_blank,
                  input  an, seg, dp, frame_tick);
  modport slave  (input  data, dp_in, digit_en, lz_blank,
                  output an, seg, dp, frame_tick);
endinterface

// File: rtl/hex2seg.sv
// Hex nibble to active-high 7-segment pattern (bits 6:0 = g..a, bit 7 unused).
// Latency: combinational; no backpressure.
module hex2seg (
  input  logic [3:0] din,
  output logic [7:0] seg_d
);
  always_comb begin
    seg_d = 8'h00;
    case (din)
      4'h0: seg_d = 8'h3F;
      4'h1: seg_d = 8'h06;
      4'h2: seg_d = 8'h5B;
      4'h3: seg_d = 8'h4F;
      4'h4: seg_d = 8'h66;
      4'h5: seg_d = 8'h6D;
      4'h6: seg_d = 8'h7D;
      4'h7: seg_d = 8'h07;
      4'h8: seg_d = 8'h7F;
      4'h9: seg_d = 8'h6F;
      4'hA: seg_d = 8'h77;
      4'hB: seg_d = 8'h7C;
      4'hC: seg_d = 8'h39;
      4'hD: seg_d = 8'h5E;
      4'hE: seg_d = 8'h79;
      default: seg_d = 8'h71;
    endcase
  end
endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with anti-ghost blanking and leading-zero blanking.
// Latency: outputs registered, 1 clk behind scan state; no backpressure (free-running).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = SCAN_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_driver_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);

  logic [CW-1:0]           div_cnt;
  logic [1:0]              idx;
  shadow_t                 shd;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic                    tick_q;

  logic [3:0]              nib;
  logic [7:0]              seg_d;
  logic [NUM_DIGITS-1:0]   sig;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    show;
  logic                    frame_start;
  logic                    unused_seg_d7;

  assign frame_start   = (div_cnt == '0) && (idx == 2'd0);
  assign nib           = shd.data[{idx, 2'b00} +: 4];
  assign unused_seg_d7 = seg_d[7];

  hex2seg u_hex2seg (
    .din   (nib),
    .seg_d (seg_d)
  );

  // A digit stays dark under lz_blank only while every digit above it is insignificant too.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++)
      sig[k] = (shd.data[4*k +: 4] != 4'h0) || shd.dp_in[k];
    blank[0] = 1'b0;
    blank[1] = shd.lz_blank & ~(sig[3] | sig[2] | sig[1]);
    blank[2] = shd.lz_blank & ~(sig[3] | sig[2]);
    blank[3] = shd.lz_blank & ~sig[3];
    show     = shd.digit_en[idx] & ~blank[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      shd     <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= frame_start;
      if (frame_start)
        shd <= '{data: bus.data, dp_in: bus.dp_in,
                 digit_en: bus.digit_en, lz_blank: bus.lz_blank};
      if (div_cnt == DIV_MAX) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (div_cnt < BLANK_V || !show) begin
        an_q  <= '1;
        seg_q <= SEG_BLANK;
        dp_q  <= 1'b1;
      end else begin
        an_q  <= ~(4'b0001 << idx);
        seg_q <= ~seg_d[6:0];
        dp_q  <= ~shd.dp_in[idx];
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (SCAN_DIV=8, BLANK_CYC=2): per-cycle expectations
// queued per frame as stimulus is applied, popped and compared one clk after each edge.
module tb_seg_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [12:0] exp_q[$];
  string       tag_q[$];

  seg_scan_driver_if bus();

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One frame = 4 slots of 8 cycles; cycles 0-1 of each slot are dark, frame_tick on slot 0 cycle 0.
  task automatic push_frame(input string tag, input logic [3:0][6:0] s,
                            input logic [3:0] vis, input logic [3:0] dpn);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) begin
        logic [12:0] v;
        if (j < 2 || !vis[i]) v = {4'hF, 7'h7F, 1'b1, (i == 0 && j == 0)};
        else                  v = {~(4'b0001 << i), s[i], dpn[i], 1'b0};
        exp_q.push_back(v);
        tag_q.push_back($sformatf("%s d%0d c%0d", tag, i, j));
      end
    end
  endtask

  task automatic drain(input int n);
    logic [12:0] obs;
    logic [12:0] expv;
    string       tag;
    repeat (n) begin
      @(posedge clk);
      #1;
      obs = {bus.an, bus.seg, bus.dp, bus.frame_tick};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL scoreboard_empty: got an=%b seg=%h dp=%b tick=%b required a queued expectation",
               obs[12:9], obs[8:2], obs[1], obs[0]);
      end else begin
        expv = exp_q.pop_front();
        tag  = tag_q.pop_front();
        assert (obs === expv) else begin
          n_err++;
          $error("FAIL %s: got an=%b seg=%h dp=%b tick=%b required an=%b seg=%h dp=%b tick=%b",
                 tag, obs[12:9], obs[8:2], obs[1], obs[0],
                 expv[12:9], expv[8:2], expv[1], expv[0]);
        end
      end
    end
  endtask

  task automatic check_reset(input string tag);
    n_vec++;
    assert ({bus.an, bus.seg, bus.dp, bus.frame_tick} === {4'hF, 7'h7F, 1'b1, 1'b0}) else begin
      n_err++;
      $error("FAIL %s: got an=%b seg=%h dp=%b tick=%b required an=1111 seg=7f dp=1 tick=0",
             tag, bus.an, bus.seg, bus.dp, bus.frame_tick);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] dpi,
                       input logic [3:0] en, input logic lz);
    bus.data     = d;
    bus.dp_in    = dpi;
    bus.digit_en = en;
    bus.lz_blank = lz;
  endtask

  initial begin
    drive(16'h12AF, 4'h0, 4'hF, 1'b0);
    #12;
    check_reset("reset_hold");
    @(negedge clk);
    rst = 1'b1;

    // 12AF: F->0e, A->08, 2->24, 1->79; first lit edge is the third after release.
    push_frame("hex_12af", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'hF);
    drain(32);

    drive(16'h0005, 4'h0, 4'hF, 1'b1);
    push_frame("lz_0005", {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b0001, 4'hF);
    drain(32);

    drive(16'h0005, 4'b0100, 4'hF, 1'b1);
    push_frame("lz_dp2", {7'h7F, 7'h40, 7'h40, 7'h12}, 4'b0111, 4'b1011);
    drain(32);

    // Input change inside slot 1 must not reach the display until the next frame.
    drive(16'h1111, 4'h0, 4'hF, 1'b0);
    push_frame("tear_1111", {7'h79, 7'h79, 7'h79, 7'h79}, 4'hF, 4'hF);
    drain(12);
    drive(16'h2222, 4'h0, 4'hF, 1'b0);
    drain(20);
    push_frame("next_2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 4'hF);
    drain(32);

    drive(16'h2222, 4'h0, 4'b1010, 1'b0);
    push_frame("en_1010", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1010, 4'hF);
    drain(32);

    // Mid-frame reset while digit 2 is lit.
    drive(16'h2222, 4'h0, 4'hF, 1'b0);
    push_frame("pre_rst", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 4'hF);
    drain(20);
    exp_q.delete();
    tag_q.delete();
    rst = 1'b0;
    #1;
    check_reset("rst_async");
    @(posedge clk);
    #1;
    check_reset("rst_held");
    @(negedge clk);
    rst = 1'b1;
    push_frame("post_rst", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 4'hF);
    drain(32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
